dff_bist: RTL and testbench
===========================

DFF_BIST -- requirements
Module: dff_bist

Interface
REQ-001 Parameter N_VECTORS, default 100; number of test vectors per run, legal range 1..255.
REQ-002 Parameter LFSR_SEED, default 8'hA5; LFSR load value at start of run.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 i_start  input  1  one-cycle request to begin a run.
REQ-006 o_d  output  1  registered stimulus bit, driven to the flip-flop under test data input.
REQ-007 i_q  input  1  flip-flop under test output.
REQ-008 i_qb  input  1  flip-flop under test complement output.
REQ-009 o_busy  output  1  high in RUN and DRAIN.
REQ-010 o_done  output  1  high in DONE.
REQ-011 o_pass_cnt  output  8  count of vectors where i_q and i_qb matched.
REQ-012 o_fail_cnt  output  8  count of vectors that mismatched.
REQ-013 o_pass  output  1  high in DONE when o_fail_cnt == 0 and o_pass_cnt == N_VECTORS.

Function
REQ-014 FSM states IDLE, RUN, DRAIN, DONE; encoding is free.
REQ-015 IDLE -> RUN on i_start=1: load LFSR with LFSR_SEED (8'h01 if seed is 0), clear both counters and the issue counter.
REQ-016 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1; shifts once per RUN cycle; o_d <= lfsr[0] each RUN cycle.
REQ-017 RUN issues exactly N_VECTORS bits, one per cycle; after the last issue, go to DRAIN.
REQ-018 Expected-value pipeline, 2 stages: a bit issued on o_d at edge t is compared against i_q/i_qb sampled at edge t+2.
REQ-019 Compare rule: pass iff i_q == exp and i_qb == ~exp; otherwise fail; exactly one counter increments per valid compare.
REQ-020 Only slots carrying a valid issued bit are compared; a valid flag travels with the expected pipeline.
REQ-021 DRAIN lasts exactly 2 cycles, flushing the pipeline, then DONE; total compares == N_VECTORS.
REQ-022 Counters saturate at 8'hFF and never wrap.
REQ-023 o_d holds its last value outside RUN.
REQ-024 i_start in RUN or DRAIN is ignored.
REQ-025 In DONE, outputs hold; i_start=1 behaves as in REQ-015 and moves to RUN next cycle.
REQ-026 o_pass is 0 in every state except DONE.

Reset
REQ-027 reset=0 at a rising edge forces IDLE, o_d=0, counters=0, pipeline valid flags=0, LFSR=LFSR_SEED, o_busy=o_done=o_pass=0, regardless of state.
REQ-028 reset=0 takes priority over i_start on the same edge.
REQ-029 Reset mid-RUN discards all partial results; no compare of in-flight bits occurs after reset.

Verification
REQ-030 Bench scenarios: the bench instantiates this block with a reference flip-flop (i_d<=o_d, q/qb back into i_q/i_qb).
REQ-031 Good flip-flop, defaults, one i_start pulse -> DRAIN after 100 issue cycles, DONE 2 cycles later; pass_cnt=100, fail_cnt=0, o_pass=1.
REQ-032 i_q tied to 0, i_qb tied to 1 -> fail_cnt equals the number of 1s in the first 100 LFSR output bits from seed 8'hA5; pass_cnt=100-fail_cnt; o_pass=0.
REQ-033 i_qb tied to i_q -> fail_cnt=100, pass_cnt=0, o_pass=0.
REQ-034 reset=0 for one cycle at RUN cycle 40 -> next cycle IDLE, counters=0, o_busy=0; a new i_start gives full 100-vector result.
REQ-035 i_start pulsed at RUN cycle 10 and again in DONE -> first pulse has no effect; second pulse clears counters and repeats an identical result.

Source files
------------

// File: rtl/dff_bist.sv
// Built-in self test for a single D flip-flop: drives LFSR stimulus on o_d and
// checks the returned q/qb pair two edges later, counting pass/fail vectors.
module dff_bist #(
  parameter int unsigned N_VECTORS = 100,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  output logic       o_d,
  input  logic       i_q,
  input  logic       i_qb,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_pass_cnt,
  output logic [7:0] o_fail_cnt,
  output logic       o_pass
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned PIPE_W   = 2;
  localparam logic [CNT_W-1:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VECTORS - 1);
  localparam logic [CNT_W-1:0] N_TOTAL  = CNT_W'(N_VECTORS);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_lfsr;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic               r_drain_cnt;
  logic [PIPE_W-1:0]  r_exp;
  logic [PIPE_W-1:0]  r_vld;

  logic               w_start_run;
  logic               w_issue;
  logic               w_fb;
  logic               w_cmp_ok;
  logic [CNT_W-1:0]   w_pass_cnt_nxt;
  logic [CNT_W-1:0]   w_fail_cnt_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_pass_nxt;

  assign w_start_run = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_issue     = (r_state == S_RUN);
  assign w_fb        = r_lfsr[0] ^ r_lfsr[4] ^ r_lfsr[5] ^ r_lfsr[6];
  assign w_cmp_ok    = (i_q == r_exp[PIPE_W-1]) && (i_qb == ~r_exp[PIPE_W-1]);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (r_issue_cnt == LAST_IDX) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain_cnt) w_state_nxt = S_DONE;
      S_DONE:  if (i_start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / counter next values; a new run clears the counters before any compare
  always_comb begin
    w_pass_cnt_nxt = o_pass_cnt;
    w_fail_cnt_nxt = o_fail_cnt;
    if (w_start_run) begin
      w_pass_cnt_nxt = '0;
      w_fail_cnt_nxt = '0;
    end else if (r_vld[PIPE_W-1]) begin
      if (w_cmp_ok) begin
        if (o_pass_cnt != CNT_MAX) w_pass_cnt_nxt = CNT_W'(o_pass_cnt + 8'd1);
      end else begin
        if (o_fail_cnt != CNT_MAX) w_fail_cnt_nxt = CNT_W'(o_fail_cnt + 8'd1);
      end
    end
    w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_pass_nxt = (w_state_nxt == S_DONE) && (w_fail_cnt_nxt == '0) &&
                 (w_pass_cnt_nxt == N_TOTAL);
  end

  // Stimulus generator, expected-value pipeline and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lfsr      <= LFSR_SEED;
      r_issue_cnt <= '0;
      r_drain_cnt <= 1'b0;
      r_exp       <= '0;
      r_vld       <= '0;
      o_d         <= 1'b0;
      o_pass_cnt  <= '0;
      o_fail_cnt  <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
    end else begin
      r_vld <= {r_vld[0], w_issue};
      r_exp <= {r_exp[0], r_lfsr[0]};
      if (w_start_run) begin
        r_lfsr      <= SEED_EFF;
        r_issue_cnt <= '0;
      end else if (w_issue) begin
        r_lfsr      <= {w_fb, r_lfsr[CNT_W-1:1]};
        r_issue_cnt <= CNT_W'(r_issue_cnt + 8'd1);
        o_d         <= r_lfsr[0];
      end
      r_drain_cnt <= (r_state == S_DRAIN);
      o_pass_cnt  <= w_pass_cnt_nxt;
      o_fail_cnt  <= w_fail_cnt_nxt;
      o_busy      <= w_busy_nxt;
      o_done      <= w_done_nxt;
      o_pass      <= w_pass_nxt;
    end
  end

endmodule

// File: tb/tb_dff_bist.sv
// Self-checking bench for dff_bist: reference flip-flop in the loop, fault modes
// and random response corruption scored against a sequence-level LFSR model.
module tb_dff_bist;

  localparam int unsigned NV   = 100;
  localparam logic [7:0]  SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic       start2;
  logic       o_d, o_busy, o_done, o_pass;
  logic [7:0] pass_cnt, fail_cnt;
  logic       ff_q = 1'b0;
  logic       inj = 1'b0;
  int         mode = 0;
  logic       w_q, w_qb;

  logic       o_d2, busy2, done2, pass2;
  logic [7:0] pass_cnt2, fail_cnt2;
  logic       ff2_q = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit ref_bits [0:NV-1];

  always #5 clk = ~clk;

  // Reference flip-flop, optional data corruption, and fault-mode muxing
  always @(posedge clk) ff_q  <= o_d ^ inj;
  always @(posedge clk) ff2_q <= o_d2;
  assign w_q  = (mode == 1) ? 1'b0 : ff_q;
  assign w_qb = (mode == 1) ? 1'b1 : ((mode == 2) ? ff_q : ~ff_q);

  dff_bist #(.N_VECTORS(NV), .LFSR_SEED(SEED)) u_dut (
    .clk(clk), .reset(reset), .i_start(i_start), .o_d(o_d),
    .i_q(w_q), .i_qb(w_qb), .o_busy(o_busy), .o_done(o_done),
    .o_pass_cnt(pass_cnt), .o_fail_cnt(fail_cnt), .o_pass(o_pass)
  );

  dff_bist #(.N_VECTORS(1), .LFSR_SEED(8'h00)) u_dut_min (
    .clk(clk), .reset(reset), .i_start(start2), .o_d(o_d2),
    .i_q(ff2_q), .i_qb(~ff2_q), .o_busy(busy2), .o_done(done2),
    .o_pass_cnt(pass_cnt2), .o_fail_cnt(fail_cnt2), .o_pass(pass2)
  );

  // Output sequence of the LFSR from its recurrence a[n+8] = a[n+6]^a[n+5]^a[n+4]^a[n]
  task automatic build_model();
    bit a [0:NV+7];
    for (int i = 0; i < 8; i++) a[i] = SEED[i];
    for (int n = 0; n < NV; n++) a[n+8] = a[n+6] ^ a[n+5] ^ a[n+4] ^ a[n];
    for (int n = 0; n < NV; n++) ref_bits[n] = a[n];
  endtask

  task automatic run_full(input int m, input int glitch_k, input bit rnd, input string name);
    int exp_fail;
    int cyc;
    bit corrupt [0:NV-1];
    mode = m;
    exp_fail = 0;
    for (int k = 0; k < NV; k++) corrupt[k] = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
    for (int k = 0; k < NV; k++) begin
      case (m)
        1:       exp_fail += int'(ref_bits[k]);
        2:       exp_fail += 1;
        default: exp_fail += int'(corrupt[k]);
      endcase
    end
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0 || pass_cnt !== 8'd0 || fail_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL %s start: busy=%b done=%b pass_cnt=%0d fail_cnt=%0d, required 1 0 0 0",
               name, o_busy, o_done, pass_cnt, fail_cnt);
    end
    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      i_start = (k == glitch_k);
      inj = corrupt[k];
      n_checks++;
      if (o_d !== ref_bits[k]) begin
        n_fail++;
        $display("FAIL %s o_d[%0d]: got %b, required %b", name, k, o_d, ref_bits[k]);
      end
    end
    i_start = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s drain_entry: busy=%b done=%b, required 1 0", name, o_busy, o_done);
    end
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 8) begin
      @(posedge clk); #1;
      inj = 1'b0;
      cyc++;
    end
    inj = 1'b0;
    n_checks++;
    if (cyc != 2) begin
      n_fail++;
      $display("FAIL %s drain_len: got %0d cycles to done, required 2", name, cyc);
    end
    n_checks++;
    if (pass_cnt !== 8'(NV - exp_fail) || fail_cnt !== 8'(exp_fail) ||
        o_pass !== (exp_fail == 0) || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: pass_cnt=%0d fail_cnt=%0d pass=%b busy=%b, required %0d %0d %b 0",
               name, pass_cnt, fail_cnt, o_pass, o_busy, NV - exp_fail, exp_fail, exp_fail == 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    i_start = 1'b1;
    start2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 || o_d !== 1'b0 ||
        pass_cnt !== 8'd0 || fail_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b pass=%b d=%b pc=%0d fc=%0d, required all 0",
               o_busy, o_done, o_pass, o_d, pass_cnt, fail_cnt);
    end
    reset = 1'b1;
    i_start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_reset_mid_run();
    mode = 0;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || pass_cnt !== 8'd0 || fail_cnt !== 8'd0 || o_d !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b done=%b pc=%0d fc=%0d d=%b, required 0 0 0 0 0",
               o_busy, o_done, pass_cnt, fail_cnt, o_d);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || pass_cnt !== 8'd0 || fail_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset_flush: busy=%b pc=%0d fc=%0d, required 0 0 0", o_busy, pass_cnt, fail_cnt);
    end
    run_full(0, -1, 1'b0, "after_reset");
  endtask

  task automatic test_restart_in_done();
    run_full(0, 10, 1'b0, "glitch_start");
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (o_done !== 1'b1 || pass_cnt !== 8'(NV) || fail_cnt !== 8'd0 || o_pass !== 1'b1) begin
      n_fail++;
      $display("FAIL done_hold: done=%b pc=%0d fc=%0d pass=%b, required 1 %0d 0 1",
               o_done, pass_cnt, fail_cnt, o_pass, NV);
    end
    run_full(0, -1, 1'b0, "rerun");
  endtask

  task automatic test_min_run();
    bit exp_d;
    exp_d = 1'b1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (o_d2 !== exp_d || busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL min_first_bit: d=%b busy=%b, required %b 1", o_d2, busy2, exp_d);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (done2 !== 1'b1 || pass_cnt2 !== 8'd1 || fail_cnt2 !== 8'd0 || pass2 !== 1'b1 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL min_result: done=%b pc=%0d fc=%0d pass=%b busy=%b, required 1 1 0 1 0",
               done2, pass_cnt2, fail_cnt2, pass2, busy2);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    run_full(0, -1, 1'b0, "good_ff");
    run_full(1, -1, 1'b0, "stuck_q0");
    run_full(2, -1, 1'b0, "qb_tied");
    test_reset_mid_run();
    test_restart_in_done();
    for (int r = 0; r < 3; r++) run_full(0, -1, 1'b1, "random_corrupt");
    test_min_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
